// File: rtl/match_judge.sv
// match_judge: latches a pair of tile picks on Enter, looks up their symbols,
// judges the pair (match / miss / illegal), keeps hit/miss scores and the
// revealed-tile mask, and detects win/lose end of game with keyboard restart.
module match_judge #(
  parameter int         N_TILES      = 16,
  parameter int         IDX_W        = $clog2(N_TILES),
  parameter int         SYM_W        = 3,
  parameter int         CNT_W        = 4,
  parameter int         WIN_HITS     = N_TILES / 2,
  parameter int         MAX_MISS     = 8,
  parameter logic [7:0] ENTER_CODE   = 8'h5A,
  parameter logic [7:0] RESTART_CODE = 8'h2D
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     NewKB,
  input  logic [7:0]               KB_DAT,
  input  logic [IDX_W-1:0]         pick_a,
  input  logic [IDX_W-1:0]         pick_b,
  input  logic [N_TILES*SYM_W-1:0] sym_flat,
  output logic [CNT_W-1:0]         ccount,
  output logic [CNT_W-1:0]         wcount,
  output logic [N_TILES-1:0]       flip,
  output logic                     keyenter,
  output logic                     datareset,
  output logic                     match,
  output logic                     illegal,
  output logic                     busy,
  output logic                     game_over,
  output logic                     win
);

  typedef enum logic [1:0] {IDLE, LATCH, JUDGE, OVER} state_t;

  // A win target the counter can never hold must never fire through truncation.
  localparam bit             WIN_REACH = (WIN_HITS < (2 ** CNT_W));
  localparam bit             LOSE_ON   = (MAX_MISS != 0) && (MAX_MISS < (2 ** CNT_W));
  localparam logic [CNT_W-1:0] WIN_V   = CNT_W'(WIN_HITS);
  localparam logic [CNT_W-1:0] LOSE_V  = CNT_W'(MAX_MISS);

  state_t             state;
  logic [IDX_W-1:0]   idx_a, idx_b;
  logic [SYM_W-1:0]   sym_a, sym_b;
  logic [SYM_W-1:0]   sym_tab [N_TILES];

  logic               enter, restart;
  logic               pair_illegal, pair_match, pair_miss;
  logic [CNT_W-1:0]   ccount_nxt, wcount_nxt;
  logic [N_TILES-1:0] flip_nxt;
  logic               end_win, end_lose;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign enter   = NewKB && (KB_DAT == ENTER_CODE);
  assign restart = NewKB && (KB_DAT == RESTART_CODE);
  assign busy    = (state == LATCH) || (state == JUDGE);

  for (genvar i = 0; i < N_TILES; i++) begin : g_sym
    assign sym_tab[i] = sym_flat[i*SYM_W +: SYM_W];
  end

  // Pick and symbol holding registers; pure data, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && enter) begin
      idx_a <= pick_a;
      idx_b <= pick_b;
    end
    if (state == LATCH) begin
      sym_a <= sym_tab[idx_a];
      sym_b <= sym_tab[idx_b];
    end
  end

  // Outcome of the latched pair and the score/mask it would produce.
  always_comb begin
    pair_illegal = (idx_a == idx_b) || flip[idx_a] || flip[idx_b];
    pair_match   = !pair_illegal && (sym_a == sym_b);
    pair_miss    = !pair_illegal && !pair_match;
    ccount_nxt   = pair_match ? sat_inc(ccount) : ccount;
    wcount_nxt   = pair_miss  ? sat_inc(wcount) : wcount;
    flip_nxt     = flip;
    if (pair_match) begin
      flip_nxt[idx_a] = 1'b1;
      flip_nxt[idx_b] = 1'b1;
    end
    end_win  = WIN_REACH && (ccount_nxt == WIN_V);
    end_lose = LOSE_ON && (wcount_nxt == LOSE_V);
  end

  // Game FSM with registered scores, mask, pulses and end-of-game flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ccount    <= '0;
      wcount    <= '0;
      flip      <= '0;
      keyenter  <= 1'b0;
      datareset <= 1'b0;
      match     <= 1'b0;
      illegal   <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      keyenter  <= 1'b0;
      datareset <= 1'b0;
      match     <= 1'b0;
      illegal   <= 1'b0;
      if (restart) begin
        // Restart wins over everything, including a judgement in flight.
        state     <= IDLE;
        ccount    <= '0;
        wcount    <= '0;
        flip      <= '0;
        game_over <= 1'b0;
        win       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (enter) state <= LATCH;
          LATCH: state <= JUDGE;
          JUDGE: begin
            ccount    <= ccount_nxt;
            wcount    <= wcount_nxt;
            flip      <= flip_nxt;
            keyenter  <= 1'b1;
            datareset <= 1'b1;
            match     <= pair_match;
            illegal   <= pair_illegal;
            if (end_win || end_lose) begin
              state     <= OVER;
              game_over <= 1'b1;
              win       <= end_win;
            end else begin
              state <= IDLE;
            end
          end
          OVER: state <= OVER;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/match_judge.md
# match_judge

Parametrised pair-judging and scoring engine for the memory-match game. It latches two tile picks when the keyboard Enter code arrives and looks up each tile's symbol in the flattened tile-symbol bus. It then judges the pair as match, miss or illegal, and updates the hit/miss counters and the per-tile flip mask. It detects win/lose end of game and supports a keyboard restart. It sits between the keyboard decoder / cursor logic and the display and score blocks, and generalises the fixed 16-tile, 3-bit-symbol judge.

## Interface
Parameters:
- N_TILES, 16, number of tiles; power of two, 4..64
- IDX_W, $clog2(N_TILES), tile index width
- SYM_W, 3, symbol width per tile
- CNT_W, 4, width of ccount/wcount
- WIN_HITS, N_TILES/2, ccount value that ends the game as a win
- MAX_MISS, 8, wcount value that ends the game as a loss; 0 disables loss
- ENTER_CODE, 8'h5A, scan code that triggers judging
- RESTART_CODE, 8'h2D, scan code that restarts the game

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- NewKB  in  1  one-cycle strobe: KB_DAT holds a new scan code
- KB_DAT  in  8  keyboard scan code
- pick_a, pick_b  in  IDX_W  selected tile indices (linear, 0..N_TILES-1)
- sym_flat  in  N_TILES*SYM_W  tile i symbol at [i*SYM_W +: SYM_W]; static during a judgement
- ccount, wcount  out  CNT_W  hit / miss counters
- flip  out  N_TILES  bit i = tile i permanently revealed
- keyenter  out  1  one-cycle pulse: a judgement completed (match, miss or illegal)
- datareset  out  1  one-cycle pulse, coincident with keyenter: upstream clears picks
- match  out  1  one-cycle pulse with keyenter when the pair matched
- illegal  out  1  one-cycle pulse with keyenter when the pair was rejected
- busy  out  1  high in LATCH and JUDGE
- game_over  out  1  level; game finished
- win  out  1  level; valid while game_over is high (1 = won, 0 = lost)

## Operation
- Trigger conditions:
  - enter = NewKB & (KB_DAT==ENTER_CODE).
  - restart = NewKB & (KB_DAT==RESTART_CODE).
- IDLE:
  - enter -> LATCH; pick_a and pick_b are registered into idx_a and idx_b.
  - Other codes are ignored.
- LATCH: sym_a <= symbol[idx_a], sym_b <= symbol[idx_b]; -> JUDGE.
- JUDGE: exactly one outcome, then -> IDLE, or -> OVER if an end condition is met.
  - illegal if idx_a==idx_b, flip[idx_a]==1 or flip[idx_b]==1. Counters and flip are unchanged; illegal pulses.
  - match if legal and sym_a==sym_b. ccount+1; flip[idx_a] and flip[idx_b] are set; match pulses.
  - miss otherwise. wcount+1.
  - keyenter and datareset pulse for every outcome.
- End conditions, evaluated on the post-update counter values in JUDGE:
  - ccount==WIN_HITS -> OVER with win=1.
  - wcount==MAX_MISS (with MAX_MISS!=0) -> OVER with win=0.
  - Win has priority; both cannot occur in the same judgement.
- OVER:
  - game_over=1 and all counters are frozen.
  - enter is ignored, with no keyenter pulse.
- Restart:
  - restart is accepted in any state.
  - It clears ccount, wcount, flip, game_over, win and every pulse output, and forces the state to IDLE.
  - restart takes priority over a same-cycle enter and over an in-flight judgement; that judgement is discarded.
- Counter width: counters saturate at 2^CNT_W-1 and never wrap.
- Overlapping keys: enter received while busy is dropped, not queued.

## Timing
- Reset value: all outputs 0 and the state is IDLE.
- Judgement latency, with edge E sampling enter in IDLE:
  - E: the picks are latched.
  - E+1: the symbols are latched.
  - E+2: counters, flip, the pulse outputs, and game_over/win are updated.
  - Pulses are high for exactly the one cycle after E+2.
- busy is high from after E until after E+2.
- Throughput: a new enter is accepted at E+3 at the earliest.
- Restart latency: outputs are cleared at the edge that samples restart.
- Mid-judgement reset: async reset at any time gives the reset values immediately, with no partial update.

## Test plan
- Legal match: tiles 3 and 9 both hold symbol 5, picks (3,9), enter -> after 3 edges ccount=1, flip=16'h0208, match=keyenter=datareset=1 for 1 cycle.
- Miss, then illegal repeat:
  - Symbols at tiles 0 and 1 differ, picks (0,1), enter -> wcount=1, flip unchanged.
  - Then picks (3,3) -> illegal=1 with keyenter=1, counters unchanged.
- Win: 8 successive legal matches on the default parameters -> after the 8th, ccount=8, flip=16'hFFFF, game_over=1, win=1. A further enter produces no keyenter.
- Loss and restart:
  - 8 misses -> game_over=1, win=0.
  - restart -> next cycle ccount=wcount=0, flip=0, game_over=0, and enter is accepted again.
- Collisions:
  - enter asserted while busy -> only one judgement occurs.
  - restart on the cycle JUDGE would update -> counters end at 0, no pulses.
  - Async reset mid-LATCH -> all outputs 0.
- Parameter sweep: N_TILES=4, SYM_W=1, CNT_W=2, MAX_MISS=0 -> 2 matches win; 5 misses saturate wcount at 3 and never cause a loss.
